// File: rtl/display_buffer.sv
// display_buffer: 80x50 character memory with cursor overlay and a byte-wide
// CPU register port. Optional rectangular fill/invert blit engine is built
// when DISPLAY_BUFFER_BLIT_EN is defined; otherwise Busy is tied low.
//
// Register handshake: RegWrite and RegRead are single-cycle strobes sampled on
// the rising edge of Clock, with no backpressure. A write takes effect at that
// edge. RegRData is loaded at the edge where RegRead=1 (pre-write value on a
// same-register collision) and holds its value at all other times.
module display_buffer #(
  parameter int COLS      = 80,
  parameter int ROWS      = 50,
  parameter int BLINK_DIV = 25000000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [11:0] DisplayAddr,
  output logic [7:0]  DisplayChar,
  output logic        CursorEnable,
  input  logic [3:0]  RegAddr,
  input  logic [7:0]  RegWData,
  input  logic        RegWrite,
  input  logic        RegRead,
  output logic [7:0]  RegRData,
  output logic        Busy
);

  localparam int CELLS = COLS * ROWS;

  localparam logic [3:0] REG_CURSOR_X    = 4'd0;
  localparam logic [3:0] REG_CURSOR_Y    = 4'd1;
  localparam logic [3:0] REG_CURSOR_MODE = 4'd2;
  localparam logic [3:0] REG_WRITE_X     = 4'd3;
  localparam logic [3:0] REG_WRITE_Y     = 4'd4;
  localparam logic [3:0] REG_CHAR_DATA   = 4'd5;
`ifdef DISPLAY_BUFFER_BLIT_EN
  localparam logic [3:0] REG_BLIT_X      = 4'd6;
  localparam logic [3:0] REG_BLIT_Y      = 4'd7;
  localparam logic [3:0] REG_BLIT_W      = 4'd8;
  localparam logic [3:0] REG_BLIT_H      = 4'd9;
  localparam logic [3:0] REG_FILL_CHAR   = 4'd10;
  localparam logic [3:0] REG_BLIT_CMD    = 4'd11;
`endif

  // Character memory; deliberately not reset so screen contents survive Reset.
  logic [7:0]  r_mem [0:CELLS-1];

  // CPU-visible registers
  logic [7:0]  r_cursor_x;
  logic [7:0]  r_cursor_y;
  logic [1:0]  r_cursor_mode;
  logic [7:0]  r_write_x;
  logic [7:0]  r_write_y;
  logic [7:0]  r_rdata;

  // Cursor blink
  logic [31:0] r_blink_cnt;
  logic        r_blink_phase;

  // Shared wires
  logic        w_busy;
  logic        w_wr_ok;
  logic [11:0] w_wr_addr;
  logic        w_char_wr;
  logic [7:0]  w_char_rd;
  logic        w_blit_we;
  logic [11:0] w_blit_addr;
  logic [7:0]  w_blit_data;
  logic        w_mem_we;
  logic [11:0] w_mem_addr;
  logic [7:0]  w_mem_data;
  logic [7:0]  w_rdata;
  logic [15:0] w_cur_lin;
  logic        w_disp_ok;

  // ---------------------------------------------------------------------------
  // CPU write cursor: linear address and range check for (WriteX, WriteY)
  // ---------------------------------------------------------------------------
  assign w_wr_ok   = (16'(r_write_x) < 16'(COLS)) && (16'(r_write_y) < 16'(ROWS));
  assign w_wr_addr = 12'(r_write_y) * 12'(COLS) + 12'(r_write_x);
  assign w_char_wr = RegWrite && (RegAddr == REG_CHAR_DATA) && w_wr_ok && !w_busy;
  assign w_char_rd = w_wr_ok ? r_mem[w_wr_addr] : 8'h00;

`ifdef DISPLAY_BUFFER_BLIT_EN
  // ---------------------------------------------------------------------------
  // Blit engine: registers, latched operands and two-process FSM
  // ---------------------------------------------------------------------------
  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [7:0]  r_blit_x;
  logic [7:0]  r_blit_y;
  logic [7:0]  r_blit_w;
  logic [7:0]  r_blit_h;
  logic [7:0]  r_fill_char;

  logic [7:0]  r_lat_x;
  logic [7:0]  r_lat_y;
  logic [7:0]  r_lat_w;
  logic [7:0]  r_lat_h;
  logic [7:0]  r_lat_fill;
  logic [7:0]  r_lat_cmd;
  logic [7:0]  r_off_x;
  logic [7:0]  r_off_y;

  logic        w_start;
  logic        w_last;
  logic [8:0]  w_cell_x;
  logic [8:0]  w_cell_y;
  logic        w_cell_ok;
  logic [7:0]  w_blit_rd;

  assign w_busy  = (r_state == S_RUN);
  assign w_start = RegWrite && (RegAddr == REG_BLIT_CMD) &&
                   ((RegWData == 8'd1) || (RegWData == 8'd2)) &&
                   (r_blit_w != 8'd0) && (r_blit_h != 8'd0) &&
                   (r_state == S_IDLE);
  assign w_last  = (r_off_x == r_lat_w - 8'd1) && (r_off_y == r_lat_h - 8'd1);

  // 9-bit sums so a rectangle hanging off the right/bottom edge never wraps
  assign w_cell_x    = {1'b0, r_lat_x} + {1'b0, r_off_x};
  assign w_cell_y    = {1'b0, r_lat_y} + {1'b0, r_off_y};
  assign w_cell_ok   = (16'(w_cell_x) < 16'(COLS)) && (16'(w_cell_y) < 16'(ROWS));
  assign w_blit_addr = 12'(w_cell_y) * 12'(COLS) + 12'(w_cell_x);
  assign w_blit_rd   = w_cell_ok ? r_mem[w_blit_addr] : 8'h00;
  assign w_blit_we   = (r_state == S_RUN) && w_cell_ok;
  assign w_blit_data = (r_lat_cmd == 8'd1) ? r_lat_fill : (w_blit_rd ^ 8'h80);

  // FSM state register
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // FSM next-state: start on an accepted command, stop after the last cell
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_next = S_RUN;
      S_RUN:   if (w_last)  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Operand latch at start and row-major cell walker during RUN
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_lat_x    <= 8'd0;
      r_lat_y    <= 8'd0;
      r_lat_w    <= 8'd0;
      r_lat_h    <= 8'd0;
      r_lat_fill <= 8'd0;
      r_lat_cmd  <= 8'd0;
      r_off_x    <= 8'd0;
      r_off_y    <= 8'd0;
    end else if (w_start) begin
      r_lat_x    <= r_blit_x;
      r_lat_y    <= r_blit_y;
      r_lat_w    <= r_blit_w;
      r_lat_h    <= r_blit_h;
      r_lat_fill <= r_fill_char;
      r_lat_cmd  <= RegWData;
      r_off_x    <= 8'd0;
      r_off_y    <= 8'd0;
    end else if (r_state == S_RUN) begin
      if (r_off_x == r_lat_w - 8'd1) begin
        r_off_x <= 8'd0;
        r_off_y <= r_off_y + 8'd1;
      end else begin
        r_off_x <= r_off_x + 8'd1;
      end
    end
  end
`else
  assign w_busy      = 1'b0;
  assign w_blit_we   = 1'b0;
  assign w_blit_addr = 12'd0;
  assign w_blit_data = 8'h00;
`endif

  // ---------------------------------------------------------------------------
  // Memory write port shared by CPU stores and the blit engine. The two never
  // collide because CharData stores are dropped while a blit runs.
  // ---------------------------------------------------------------------------
  assign w_mem_we   = w_char_wr || w_blit_we;
  assign w_mem_addr = w_char_wr ? w_wr_addr : w_blit_addr;
  assign w_mem_data = w_char_wr ? RegWData  : w_blit_data;

  // Memory write (no reset on purpose)
  always_ff @(posedge Clock) begin
    if (w_mem_we) r_mem[w_mem_addr] <= w_mem_data;
  end

  // Register file writes, including the CharData auto-increment
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_cursor_x    <= 8'd0;
      r_cursor_y    <= 8'd0;
      r_cursor_mode <= 2'd0;
      r_write_x     <= 8'd0;
      r_write_y     <= 8'd0;
`ifdef DISPLAY_BUFFER_BLIT_EN
      r_blit_x      <= 8'd0;
      r_blit_y      <= 8'd0;
      r_blit_w      <= 8'd0;
      r_blit_h      <= 8'd0;
      r_fill_char   <= 8'd0;
`endif
    end else if (RegWrite) begin
      case (RegAddr)
        REG_CURSOR_X:    r_cursor_x    <= RegWData;
        REG_CURSOR_Y:    r_cursor_y    <= RegWData;
        REG_CURSOR_MODE: r_cursor_mode <= RegWData[1:0];
        REG_WRITE_X:     r_write_x     <= RegWData;
        REG_WRITE_Y:     r_write_y     <= RegWData;
        REG_CHAR_DATA: begin
          if (w_char_wr) begin
            if (16'(r_write_x) == 16'(COLS - 1)) begin
              r_write_x <= 8'd0;
              if (16'(r_write_y) == 16'(ROWS - 1)) r_write_y <= 8'd0;
              else                                 r_write_y <= r_write_y + 8'd1;
            end else begin
              r_write_x <= r_write_x + 8'd1;
            end
          end
        end
`ifdef DISPLAY_BUFFER_BLIT_EN
        REG_BLIT_X:      r_blit_x      <= RegWData;
        REG_BLIT_Y:      r_blit_y      <= RegWData;
        REG_BLIT_W:      r_blit_w      <= RegWData;
        REG_BLIT_H:      r_blit_h      <= RegWData;
        REG_FILL_CHAR:   r_fill_char   <= RegWData;
`endif
        default: ;
      endcase
    end
  end

  // Read mux: reserved and absent registers read as zero
  always_comb begin
    w_rdata = 8'h00;
    case (RegAddr)
      REG_CURSOR_X:    w_rdata = r_cursor_x;
      REG_CURSOR_Y:    w_rdata = r_cursor_y;
      REG_CURSOR_MODE: w_rdata = {6'd0, r_cursor_mode};
      REG_WRITE_X:     w_rdata = r_write_x;
      REG_WRITE_Y:     w_rdata = r_write_y;
      REG_CHAR_DATA:   w_rdata = w_char_rd;
`ifdef DISPLAY_BUFFER_BLIT_EN
      REG_BLIT_X:      w_rdata = r_blit_x;
      REG_BLIT_Y:      w_rdata = r_blit_y;
      REG_BLIT_W:      w_rdata = r_blit_w;
      REG_BLIT_H:      w_rdata = r_blit_h;
      REG_FILL_CHAR:   w_rdata = r_fill_char;
      REG_BLIT_CMD:    w_rdata = w_busy ? r_lat_cmd : 8'h00;
`endif
      default:         w_rdata = 8'h00;
    endcase
  end

  // Registered read data, held between read strobes
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)        r_rdata <= 8'h00;
    else if (RegRead) r_rdata <= w_rdata;
  end

  // Blink phase toggles once every BLINK_DIV cycles
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_blink_cnt   <= 32'd0;
      r_blink_phase <= 1'b1;
    end else if (r_blink_cnt == 32'(BLINK_DIV - 1)) begin
      r_blink_cnt   <= 32'd0;
      r_blink_phase <= ~r_blink_phase;
    end else begin
      r_blink_cnt   <= r_blink_cnt + 32'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Scan-out side: combinational character read and cursor match. The cursor
  // address is kept 16 bits wide so an off-screen cursor never aliases.
  // ---------------------------------------------------------------------------
  assign w_disp_ok   = 16'(DisplayAddr) < 16'(CELLS);
  assign DisplayChar = w_disp_ok ? r_mem[DisplayAddr] : 8'h00;

  assign w_cur_lin    = 16'(r_cursor_y) * 16'(COLS) + 16'(r_cursor_x);
  assign CursorEnable = (16'(DisplayAddr) == w_cur_lin) &&
                        (r_cursor_mode != 2'd0) &&
                        ((r_cursor_mode != 2'd2) || r_blink_phase);

  assign RegRData = r_rdata;
  assign Busy     = w_busy;

endmodule

// File: tb/tb_display_buffer.sv
// Directed bench for display_buffer (COLS=80, ROWS=50, BLINK_DIV=4).
module tb_display_buffer;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [11:0] DisplayAddr = 12'd0;
  logic [7:0]  DisplayChar;
  logic        CursorEnable;
  logic [3:0]  RegAddr = 4'd0;
  logic [7:0]  RegWData = 8'd0;
  logic        RegWrite = 1'b0;
  logic        RegRead = 1'b0;
  logic [7:0]  RegRData;
  logic        Busy;

  int n_checks = 0;
  int n_errors = 0;

  display_buffer #(.COLS(80), .ROWS(50), .BLINK_DIV(4)) dut (
    .Clock(Clock), .Reset(Reset), .DisplayAddr(DisplayAddr),
    .DisplayChar(DisplayChar), .CursorEnable(CursorEnable),
    .RegAddr(RegAddr), .RegWData(RegWData), .RegWrite(RegWrite),
    .RegRead(RegRead), .RegRData(RegRData), .Busy(Busy)
  );

  always #5 Clock = ~Clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic reg_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge Clock);
    RegAddr = a; RegWData = d; RegWrite = 1'b1;
    @(negedge Clock);
    RegWrite = 1'b0;
  endtask

  task automatic reg_read(input logic [3:0] a, output logic [7:0] d);
    @(negedge Clock);
    RegAddr = a; RegRead = 1'b1;
    @(negedge Clock);
    RegRead = 1'b0;
    d = RegRData;
  endtask

  task automatic peek(input int addr, output logic [7:0] d);
    DisplayAddr = 12'(addr);
    #1;
    d = DisplayChar;
  endtask

  task automatic count_busy(output int cycles);
    cycles = 0;
    while (Busy === 1'b1 && cycles < 200) begin
      cycles++;
      @(negedge Clock);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [7:0] v;
    logic [3:0] regs [0:4];
    regs = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    DisplayAddr = 12'd0;
    #1;
    n_checks++;
    if (RegRData !== 8'h00) begin n_errors++; $display("FAIL reset_rdata: got %h want 00", RegRData); end
    n_checks++;
    if (Busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", Busy); end
    n_checks++;
    if (CursorEnable !== 1'b0) begin n_errors++; $display("FAIL reset_cursor: got %b want 0", CursorEnable); end
    for (int i = 0; i < 5; i++) begin
      reg_read(regs[i], v);
      n_checks++;
      if (v !== 8'h00) begin n_errors++; $display("FAIL reset_reg%0d: got %h want 00", regs[i], v); end
    end
  endtask

  task automatic test_chardata();
    logic [7:0] v;
    reg_write(4'd3, 8'd78);
    reg_write(4'd4, 8'd49);
    reg_write(4'd5, 8'h41);
    reg_write(4'd5, 8'h42);
    reg_write(4'd5, 8'h43);
    peek(3998, v);
    n_checks++;
    if (v !== 8'h41) begin n_errors++; $display("FAIL char_3998: got %h want 41", v); end
    peek(3999, v);
    n_checks++;
    if (v !== 8'h42) begin n_errors++; $display("FAIL char_3999: got %h want 42", v); end
    peek(0, v);
    n_checks++;
    if (v !== 8'h43) begin n_errors++; $display("FAIL char_wrap0: got %h want 43", v); end
    reg_read(4'd3, v);
    n_checks++;
    if (v !== 8'd1) begin n_errors++; $display("FAIL char_writex: got %h want 01", v); end
    reg_read(4'd4, v);
    n_checks++;
    if (v !== 8'd0) begin n_errors++; $display("FAIL char_writey: got %h want 00", v); end
    // CharData read does not advance the write cursor
    reg_write(4'd3, 8'd0);
    reg_read(4'd5, v);
    n_checks++;
    if (v !== 8'h43) begin n_errors++; $display("FAIL char_read: got %h want 43", v); end
    reg_read(4'd3, v);
    n_checks++;
    if (v !== 8'd0) begin n_errors++; $display("FAIL char_read_noinc: got %h want 00", v); end
    peek(4000, v);
    n_checks++;
    if (v !== 8'h00) begin n_errors++; $display("FAIL disp_4000: got %h want 00", v); end
    peek(4095, v);
    n_checks++;
    if (v !== 8'h00) begin n_errors++; $display("FAIL disp_4095: got %h want 00", v); end
  endtask

  task automatic test_out_of_range();
    logic [7:0] v;
    reg_write(4'd3, 8'd0);
    reg_write(4'd4, 8'd1);
    reg_write(4'd5, 8'h11);            // cell 80
    reg_write(4'd3, 8'd80);
    reg_write(4'd5, 8'h77);            // x out of range: dropped
    reg_read(4'd3, v);
    n_checks++;
    if (v !== 8'd80) begin n_errors++; $display("FAIL oor_x_noinc: got %h want 50", v); end
    peek(80, v);
    n_checks++;
    if (v !== 8'h11) begin n_errors++; $display("FAIL oor_x_nostore: got %h want 11", v); end
    reg_read(4'd5, v);
    n_checks++;
    if (v !== 8'h00) begin n_errors++; $display("FAIL oor_read: got %h want 00", v); end
    reg_write(4'd3, 8'd0);
    reg_write(4'd4, 8'd50);
    reg_write(4'd5, 8'h78);            // y out of range: dropped
    reg_read(4'd4, v);
    n_checks++;
    if (v !== 8'd50) begin n_errors++; $display("FAIL oor_y_noinc: got %h want 32", v); end
    reg_read(4'd3, v);
    n_checks++;
    if (v !== 8'd0) begin n_errors++; $display("FAIL oor_y_x: got %h want 00", v); end
    peek(0, v);
    n_checks++;
    if (v !== 8'h43) begin n_errors++; $display("FAIL oor_y_nostore: got %h want 43", v); end
  endtask

  task automatic test_rw_collision();
    reg_write(4'd3, 8'd5);
    @(negedge Clock);
    RegAddr = 4'd3; RegWData = 8'h22; RegWrite = 1'b1; RegRead = 1'b1;
    @(negedge Clock);
    RegWrite = 1'b0; RegRead = 1'b0;
    n_checks++;
    if (RegRData !== 8'd5) begin n_errors++; $display("FAIL collide_old: got %h want 05", RegRData); end
    RegAddr = 4'd4;
    repeat (3) @(negedge Clock);
    n_checks++;
    if (RegRData !== 8'd5) begin n_errors++; $display("FAIL rdata_hold: got %h want 05", RegRData); end
    @(negedge Clock);
    RegAddr = 4'd3; RegRead = 1'b1;
    @(negedge Clock);
    RegRead = 1'b0;
    n_checks++;
    if (RegRData !== 8'h22) begin n_errors++; $display("FAIL collide_new: got %h want 22", RegRData); end
  endtask

  task automatic test_cursor();
    int addrs [0:6];
    logic vals [0:23];
    int t0;
    logic e;
    addrs = '{164, 165, 166, 5, 85, 245, 0};
    reg_write(4'd0, 8'd5);
    reg_write(4'd1, 8'd2);
    reg_write(4'd2, 8'd1);
    for (int i = 0; i < 7; i++) begin
      DisplayAddr = 12'(addrs[i]);
      #1;
      n_checks++;
      if (CursorEnable !== (addrs[i] == 165)) begin
        n_errors++; $display("FAIL cursor_on_addr%0d: got %b want %b", addrs[i], CursorEnable, addrs[i] == 165);
      end
    end
    reg_write(4'd2, 8'd3);
    DisplayAddr = 12'd165;
    #1;
    n_checks++;
    if (CursorEnable !== 1'b1) begin n_errors++; $display("FAIL cursor_mode3: got %b want 1", CursorEnable); end
    // blink: phase must change in runs of exactly 4 cycles
    reg_write(4'd2, 8'd2);
    for (int i = 0; i < 24; i++) begin
      @(negedge Clock);
      vals[i] = CursorEnable;
    end
    t0 = -1;
    for (int i = 1; i < 24; i++) if (t0 < 0 && vals[i] !== vals[i-1]) t0 = i;
    n_checks++;
    if (t0 < 1 || t0 > 4) begin
      n_errors++; $display("FAIL blink_first_toggle: got index %0d want 1..4", t0);
    end else begin
      for (int i = t0 + 1; i < 24; i++) begin
        e = vals[t0] ^ 1'(((i - t0) / 4) % 2);
        n_checks++;
        if (vals[i] !== e) begin n_errors++; $display("FAIL blink_cycle%0d: got %b want %b", i, vals[i], e); end
      end
    end
    reg_write(4'd2, 8'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge Clock);
      n_checks++;
      if (CursorEnable !== 1'b0) begin n_errors++; $display("FAIL cursor_off_cycle%0d: got %b want 0", i, CursorEnable); end
    end
  endtask

`ifdef DISPLAY_BUFFER_BLIT_EN
  task automatic test_fill();
    logic [7:0] v, e, base;
    int cyc, addr;
    for (int r = 0; r < 3; r++) begin
      reg_write(4'd3, 8'd76);
      reg_write(4'd4, 8'(r));
      base = 8'h10 * 8'(r + 1);
      for (int i = 0; i < 6; i++) reg_write(4'd5, base + 8'(i));
    end
    reg_write(4'd6, 8'd78);
    reg_write(4'd7, 8'd0);
    reg_write(4'd8, 8'd4);
    reg_write(4'd9, 8'd2);
    reg_write(4'd10, 8'h2A);
    reg_write(4'd11, 8'd1);
    count_busy(cyc);
    n_checks++;
    if (cyc != 8) begin n_errors++; $display("FAIL fill_busy_cycles: got %0d want 8", cyc); end
    for (int r = 0; r < 3; r++) begin
      base = 8'h10 * 8'(r + 1);
      for (int i = 0; i < 6; i++) begin
        addr = 76 + r * 80 + i;
        e = (r < 2 && (i == 2 || i == 3)) ? 8'h2A : base + 8'(i);
        peek(addr, v);
        n_checks++;
        if (v !== e) begin n_errors++; $display("FAIL fill_cell%0d: got %h want %h", addr, v, e); end
      end
    end
  endtask

  task automatic test_invert();
    logic [7:0] v;
    int cyc;
    reg_write(4'd3, 8'd10);
    reg_write(4'd4, 8'd0);
    reg_write(4'd5, 8'h41);
    reg_write(4'd5, 8'h42);
    reg_write(4'd6, 8'd10);
    reg_write(4'd7, 8'd0);
    reg_write(4'd8, 8'd1);
    reg_write(4'd9, 8'd1);
    reg_write(4'd11, 8'd2);
    count_busy(cyc);
    n_checks++;
    if (cyc != 1) begin n_errors++; $display("FAIL inv_busy_cycles: got %0d want 1", cyc); end
    peek(10, v);
    n_checks++;
    if (v !== 8'hC1) begin n_errors++; $display("FAIL inv_first: got %h want c1", v); end
    peek(11, v);
    n_checks++;
    if (v !== 8'h42) begin n_errors++; $display("FAIL inv_neighbor: got %h want 42", v); end
    reg_write(4'd11, 8'd2);
    count_busy(cyc);
    peek(10, v);
    n_checks++;
    if (v !== 8'h41) begin n_errors++; $display("FAIL inv_second: got %h want 41", v); end
  endtask

  task automatic test_busy_drop();
    logic [7:0] v;
    int cyc;
    reg_write(4'd3, 8'd0);
    reg_write(4'd4, 8'd10);
    reg_write(4'd5, 8'h55);            // cell 800
    reg_write(4'd3, 8'd0);
    reg_write(4'd6, 8'd0);
    reg_write(4'd7, 8'd20);
    reg_write(4'd8, 8'd10);
    reg_write(4'd9, 8'd2);
    reg_write(4'd10, 8'h66);
    reg_write(4'd11, 8'd1);
    reg_read(4'd11, v);
    n_checks++;
    if (v !== 8'd1) begin n_errors++; $display("FAIL cmd_read_busy: got %h want 01", v); end
    reg_write(4'd5, 8'h99);            // dropped
    reg_write(4'd11, 8'd2);            // ignored
    reg_write(4'd6, 8'd40);            // live register only; running blit keeps X=0
    n_checks++;
    if (Busy !== 1'b1) begin n_errors++; $display("FAIL busy_midrun: got %b want 1", Busy); end
    count_busy(cyc);
    n_checks++;
    if (Busy !== 1'b0) begin n_errors++; $display("FAIL busy_end: got %b want 0", Busy); end
    reg_read(4'd11, v);
    n_checks++;
    if (v !== 8'd0) begin n_errors++; $display("FAIL cmd_read_idle: got %h want 00", v); end
    reg_read(4'd3, v);
    n_checks++;
    if (v !== 8'd0) begin n_errors++; $display("FAIL drop_noinc: got %h want 00", v); end
    peek(800, v);
    n_checks++;
    if (v !== 8'h55) begin n_errors++; $display("FAIL drop_nostore: got %h want 55", v); end
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 10; i++) begin
        peek(1600 + r * 80 + i, v);
        n_checks++;
        if (v !== 8'h66) begin n_errors++; $display("FAIL drop_fill%0d: got %h want 66", 1600 + r * 80 + i, v); end
      end
    end
  endtask

  task automatic test_reset_mid_blit();
    logic [7:0] v, e;
    logic [3:0] regs [0:4];
    regs = '{4'd3, 4'd4, 4'd7, 4'd8, 4'd10};
    reg_write(4'd3, 8'd0);
    reg_write(4'd4, 8'd30);
    for (int i = 0; i < 20; i++) reg_write(4'd5, 8'h01);
    reg_write(4'd6, 8'd0);
    reg_write(4'd7, 8'd30);
    reg_write(4'd8, 8'd20);
    reg_write(4'd9, 8'd1);
    reg_write(4'd10, 8'h5A);
    reg_write(4'd11, 8'd1);
    repeat (3) @(posedge Clock);
    #2;
    Reset = 1'b1;
    #1;
    n_checks++;
    if (Busy !== 1'b0) begin n_errors++; $display("FAIL midreset_busy: got %b want 0", Busy); end
    n_checks++;
    if (RegRData !== 8'h00) begin n_errors++; $display("FAIL midreset_rdata: got %h want 00", RegRData); end
    @(negedge Clock);
    Reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      e = (i < 3) ? 8'h5A : 8'h01;
      peek(2400 + i, v);
      n_checks++;
      if (v !== e) begin n_errors++; $display("FAIL midreset_cell%0d: got %h want %h", 2400 + i, v, e); end
    end
    for (int i = 0; i < 5; i++) begin
      reg_read(regs[i], v);
      n_checks++;
      if (v !== 8'h00) begin n_errors++; $display("FAIL midreset_reg%0d: got %h want 00", regs[i], v); end
    end
    n_checks++;
    if (Busy !== 1'b0) begin n_errors++; $display("FAIL midreset_busy_after: got %b want 0", Busy); end
  endtask
`else
  task automatic test_no_blit();
    logic [7:0] v;
    reg_write(4'd6, 8'h12);
    reg_read(4'd6, v);
    n_checks++;
    if (v !== 8'h00) begin n_errors++; $display("FAIL noblit_reg6: got %h want 00", v); end
    reg_write(4'd8, 8'd1);
    reg_write(4'd9, 8'd1);
    reg_write(4'd11, 8'd1);
    n_checks++;
    if (Busy !== 1'b0) begin n_errors++; $display("FAIL noblit_busy: got %b want 0", Busy); end
    reg_read(4'd11, v);
    n_checks++;
    if (v !== 8'h00) begin n_errors++; $display("FAIL noblit_cmd: got %h want 00", v); end
    reg_write(4'd3, 8'd20);
    reg_write(4'd4, 8'd3);
    reg_write(4'd5, 8'h5C);            // cell 260, never dropped
    peek(260, v);
    n_checks++;
    if (v !== 8'h5C) begin n_errors++; $display("FAIL noblit_store: got %h want 5c", v); end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    test_reset();
    test_chardata();
    test_out_of_range();
    test_rw_collision();
    test_cursor();
`ifdef DISPLAY_BUFFER_BLIT_EN
    test_fill();
    test_invert();
    test_busy_drop();
    test_reset_mid_blit();
`else
    test_no_blit();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/display_buffer.md
# display_buffer

Character video memory and cursor/blit controller feeding the VGA text scan-out stage. Holds an 80×50 cell array addressed linearly (`Y*COLS + X`), serves the scan-out's combinational `DisplayAddr` → `DisplayChar` read, and produces `CursorEnable` for the cell under the cursor. A byte-wide CPU register port writes cells, positions the cursor and launches rectangular fill and invert blits.

## Interface
- `COLS`, 80, characters per row.
- `ROWS`, 50, character rows. `COLS*ROWS` ≤ 4096.
- `BLINK_DIV`, 25000000, `Clock` cycles per cursor blink half-period.
- `Clock` in 1: single clock for all logic.
- `Reset` in 1: asynchronous, active-high.
- `DisplayAddr` in 12: linear cell address from scan-out.
- `DisplayChar` out 8: cell byte at `DisplayAddr`. Bit 7 is the invert flag.
- `CursorEnable` out 1: cursor visible at `DisplayAddr`.
- `RegAddr` in 4: register select.
- `RegWData` in 8: write data.
- `RegWrite` in 1: write strobe, one cycle per access.
- `RegRead` in 1: read strobe.
- `RegRData` out 8: registered read data.
- `Busy` out 1: blit in progress.

## Operation
- Registers: 0 CursorX, 1 CursorY, 2 CursorMode (0 off, 1 on, 2 blink, 3 treated as on), 3 WriteX, 4 WriteY, 5 CharData, 6 BlitX, 7 BlitY, 8 BlitW, 9 BlitH, 10 FillChar, 11 BlitCmd (1 fill, 2 invert, other values ignored), 12–15 reserved (write ignored, read 0).
- CharData write:
  - Stores the byte at (WriteX, WriteY).
  - Then increments WriteX. At COLS-1, WriteX → 0 and WriteY increments; WriteY at ROWS-1 → 0.
  - Out-of-range WriteX/WriteY: no store, no increment.
  - Dropped entirely (no store, no increment) while `Busy`=1.
- CharData read returns the cell at (WriteX, WriteY) without incrementing.
- BlitCmd read returns the active command, or 0 when idle.
- Read port: `DisplayChar` = mem[`DisplayAddr`] combinationally. Addresses ≥ `COLS*ROWS` return 0x00.
- Cursor:
  - `CursorEnable` = (`DisplayAddr` == CursorY*COLS+CursorX) && mode≠0 && (mode≠2 || blinkPhase).
  - blinkPhase toggles every `BLINK_DIV` cycles.
- Blit FSM, states IDLE and RUN:
  - IDLE→RUN on BlitCmd write of 1/2 with BlitW≠0 and BlitH≠0. Otherwise the command is ignored.
  - RUN visits cells row-major from (BlitX, BlitY) to (BlitX+BlitW-1, BlitY+BlitH-1), one per cycle. Coordinates use 9-bit sums, so there is no wrap.
  - Fill writes FillChar. Invert writes the cell XOR 0x80 (read-modify-write via internal async read port).
  - Cells with x ≥ COLS or y ≥ ROWS are skipped but still consume their cycle.
  - RUN→IDLE after the last cell.
- BlitCmd writes while `Busy`=1 are ignored. Blit registers may be rewritten during RUN; the FSM uses values latched at start.
- Memory is not cleared by `Reset`.

## Timing
- Reset values:
  - `RegRData`=0x00, `Busy`=0, `CursorEnable`=0.
  - All registers 0, FSM IDLE, blinkPhase=1, blink counter 0.
- Reset mid-blit aborts immediately; cells already written stay written.
- Register write takes effect at the rising edge where `RegWrite`=1. A CharData store is visible on `DisplayChar` the following cycle.
- `RegRData` is valid the cycle after `RegRead`. It holds its last value otherwise.
- Simultaneous `RegRead` and `RegWrite` to the same register: read returns the pre-write value.
- Blit: command written at edge N → `Busy`=1 after edge N. Cell k is written at edge N+1+k. `Busy` falls after edge N+BlitW*BlitH.
- `CursorEnable` is combinational from `DisplayAddr` and registered state. No added latency.

## Configuration
- `DISPLAY_BUFFER_BLIT_EN` defined:
  - Blit FSM, registers 6–11 and `Busy` are present as above.
- Undefined:
  - Registers 6–11 write-ignored and read 0.
  - `Busy` is tied 0 and CharData writes are never dropped.
  - Internal read port removed.

## Test plan
- Reset, then WriteX=78, WriteY=49, write CharData 0x41, 0x42, 0x43 → cells 3998=0x41, 3999=0x42, 0=0x43; WriteX=1, WriteY=0.
- CursorX=5, CursorY=2, mode 1 → `CursorEnable`=1 only at `DisplayAddr`=165. Mode 2 with `BLINK_DIV`=4 → it toggles every 4 cycles. Mode 0 → always 0.
- Fill: BlitX=78, BlitY=0, W=4, H=2, FillChar=0x2A, BlitCmd=1 → `Busy` high exactly 8 cycles; cells 78, 79, 158, 159 = 0x2A; no other cell changed.
- Invert: cell 10=0x41, BlitX=10, W=1, H=1, BlitCmd=2 → cell 10=0xC1 after 1 busy cycle. Repeat → 0x41.
- During fill, write CharData and BlitCmd=2 → both dropped. BlitCmd reads 1 while busy, 0 after.
- Assert `Reset` at cycle 3 of a 20-cell fill → `Busy`=0 immediately, exactly the first 3 cells written, registers 0.
